vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 56: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 120: hsync width, in clocks.
REQ-004 SHALL have parameter H_BP, default 64: horizontal back porch, in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 600: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 37: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 6: vsync width, in lines.
REQ-008 SHALL have parameter V_BP, default 23: vertical back porch, in lines.
REQ-009 SHALL have parameter H_POL, default 1: hsync active level.
REQ-010 SHALL have parameter V_POL, default 1: vsync active level.
REQ-011 SHALL have parameter PIPE_DELAY, default 2: extra cycles applied to hsync/vsync/de when delay is compiled in.
REQ-012 SHALL have port clk48, input, 1: the single clock; all state changes on its rising edge.
REQ-013 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-014 SHALL have port hpos, output, 11: current horizontal counter, 0..H_TOTAL-1.
REQ-015 SHALL have port vpos, output, 10: current vertical counter, 0..V_TOTAL-1.
REQ-016 SHALL have port hsync, output, 1: horizontal sync at polarity H_POL.
REQ-017 SHALL have port vsync, output, 1: vertical sync at polarity V_POL.
REQ-018 SHALL have port de, output, 1: display enable, high inside the active area.
REQ-019 SHALL have port line_start, output, 1: one-cycle strobe when hpos==0.
REQ-020 SHALL have port frame_start, output, 1: one-cycle strobe when hpos==0 and vpos==0.
REQ-021 SHALL have port frame, output, 16: frame counter for animation.

Function
REQ-022 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 666).
REQ-023 SHALL increment hpos every cycle; at H_TOTAL-1 it SHALL wrap to 0 and advance vpos by one.
REQ-024 SHALL wrap vpos from V_TOTAL-1 to 0 on the same edge that hpos wraps, with both at their maximum.
REQ-025 SHALL register hsync, vsync, de, line_start and frame_start from next-state counter values, so that they describe the hpos/vpos shown in the same cycle (zero relative latency).
REQ-026 SHALL drive de=1 iff hpos<H_ACTIVE and vpos<V_ACTIVE.
REQ-027 SHALL drive hsync=H_POL iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
REQ-028 SHALL drive vsync=V_POL iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise ~V_POL.
REQ-029 SHALL increment frame (modulo 2^16, wrapping 0xFFFF->0) on each edge where the counters wrap to (0,0), coincident with frame_start rising.
REQ-030 SHALL produce exactly one line_start per H_TOTAL cycles and exactly one frame_start per H_TOTAL*V_TOTAL cycles (default 692640).

Reset
REQ-031 SHALL, while rst is high, force hpos=H_TOTAL-1, vpos=V_TOTAL-1, de=0, hsync=~H_POL, vsync=~V_POL, line_start=0, frame_start=0, frame=0xFFFF, and all delay stages to inactive.
REQ-032 SHALL present hpos=0, vpos=0, de=1, line_start=1, frame_start=1 and frame=0 on the first edge after rst falls.
REQ-033 SHALL restart from the REQ-031 state when rst is asserted mid-frame, with no partial-line sync pulse after release.

Configuration
REQ-034 SHALL, when VGA_SYNC_DELAY_EN is defined, pass hsync, vsync and de through a PIPE_DELAY-stage register chain, leaving hpos, vpos, strobes and frame undelayed.
REQ-035 SHALL, when VGA_SYNC_DELAY_EN is undefined, output hsync, vsync and de with zero extra delay and ignore PIPE_DELAY.

Verification
REQ-036 SHALL cover: release rst -> next cycle hpos=0, vpos=0, de=1, frame_start=1, frame=0.
REQ-037 SHALL cover: free run, default parameters -> hsync high exactly for hpos 856..975, de low for hpos>=800, line_start period 1040.
REQ-038 SHALL cover: run 2 frames -> vsync high exactly for vpos 637..642, frame_start period 692640, frame steps 0->1->2.
REQ-039 SHALL cover: force frame to 0xFFFF, run to the next frame wrap -> frame=0x0000.
REQ-040 SHALL cover: assert rst at hpos=900, vpos=300 for 3 cycles -> reset values held; first post-release cycle equals REQ-036.
REQ-041 SHALL cover: VGA_SYNC_DELAY_EN defined, PIPE_DELAY=2 -> de first rises 2 cycles after first frame_start; hsync rises at hpos=858.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator.
// Free-running horizontal/vertical counters plus registered sync, display
// enable and line/frame strobes. These are derived from the next-state
// counter values, so they line up with the hpos/vpos shown in the same cycle.
// Optional feature macro VGA_SYNC_DELAY_EN: when defined, hsync/vsync/de pass
// through a PIPE_DELAY-stage register chain. hpos/vpos, the strobes and frame
// are not delayed.
module vga_sync_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BP       = 64,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 23,
    parameter int H_POL      = 1,
    parameter int V_POL      = 1,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk48,
    input  logic        rst,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_MAX      = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ON      = 1'(H_POL);
    localparam logic        VS_ON      = 1'(V_POL);

`ifdef VGA_SYNC_DELAY_EN
    localparam int DELAY_STAGES = PIPE_DELAY;
`else
    // Delay disabled: no extra stages, whatever PIPE_DELAY says.
    localparam int DELAY_STAGES = 0 * PIPE_DELAY;
`endif

    logic [10:0] hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic [15:0] frame_q, frame_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        lineStart_q, lineStart_d;
    logic        frameStart_q, frameStart_d;
    logic        hWrap;
    logic        vWrap;

    // Next-state counters and the per-pixel flags decoded from those next values.
    always_comb begin
        hWrap   = (hpos_q == H_MAX);
        vWrap   = (vpos_q == V_MAX);
        hpos_d  = hWrap ? 11'd0 : hpos_q + 11'd1;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        if (hWrap) begin
            vpos_d = vWrap ? 10'd0 : vpos_q + 10'd1;
            if (vWrap) begin
                frame_d = frame_q + 16'd1;
            end
        end
        if (rst) begin
            hpos_d  = H_MAX;
            vpos_d  = V_MAX;
            frame_d = 16'hFFFF;
        end
        de_d         = !rst && (hpos_d < H_ACT) && (vpos_d < V_ACT);
        hsync_d      = (!rst && (hpos_d >= HS_START) && (hpos_d < HS_END)) ? HS_ON : ~HS_ON;
        vsync_d      = (!rst && (vpos_d >= VS_START) && (vpos_d < VS_END)) ? VS_ON : ~VS_ON;
        lineStart_d  = !rst && (hpos_d == 11'd0);
        frameStart_d = !rst && (hpos_d == 11'd0) && (vpos_d == 10'd0);
    end

    // State register for the counters, the frame count and the registered flags.
    always_ff @(posedge clk48) begin
        hpos_q       <= hpos_d;
        vpos_q       <= vpos_d;
        frame_q      <= frame_d;
        hsync_q      <= hsync_d;
        vsync_q      <= vsync_d;
        de_q         <= de_d;
        lineStart_q  <= lineStart_d;
        frameStart_q <= frameStart_d;
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame       = frame_q;
    assign line_start  = lineStart_q;
    assign frame_start = frameStart_q;

    if (DELAY_STAGES > 0) begin : gDelay
        logic [DELAY_STAGES-1:0] hsPipe_q;
        logic [DELAY_STAGES-1:0] vsPipe_q;
        logic [DELAY_STAGES-1:0] dePipe_q;

        // Shift the sync/enable flags down the delay chain; reset empties it to inactive.
        always_ff @(posedge clk48) begin
            if (rst) begin
                hsPipe_q <= {DELAY_STAGES{~HS_ON}};
                vsPipe_q <= {DELAY_STAGES{~VS_ON}};
                dePipe_q <= '0;
            end else begin
                for (int i = DELAY_STAGES - 1; i > 0; i--) begin
                    hsPipe_q[i] <= hsPipe_q[i-1];
                    vsPipe_q[i] <= vsPipe_q[i-1];
                    dePipe_q[i] <= dePipe_q[i-1];
                end
                hsPipe_q[0] <= hsync_q;
                vsPipe_q[0] <= vsync_q;
                dePipe_q[0] <= de_q;
            end
        end

        assign hsync = hsPipe_q[DELAY_STAGES-1];
        assign vsync = vsPipe_q[DELAY_STAGES-1];
        assign de    = dePipe_q[DELAY_STAGES-1];
    end else begin : gNoDelay
        assign hsync = hsync_q;
        assign vsync = vsync_q;
        assign de    = de_q;
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: self-checking bench for vga_sync_gen.
// A small-geometry instance runs several whole frames with random mid-frame
// resets. A default-geometry instance runs a few lines. Both are compared
// every cycle against an arithmetic model of the timing, which is based on
// the cycle count since reset release.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    // Small geometry: 32 clocks per line, 15 lines per frame, inverted hsync.
    localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVA = 8,  SVF = 2, SVS = 3, SVB = 2;
    localparam int SHP = 0,  SVP = 1;
    localparam int S_HT = SHA + SHF + SHS + SHB;
    localparam int S_FT = S_HT * (SVA + SVF + SVS + SVB);

    // Default geometry.
    localparam int DHA = 800, DHF = 56, DHS = 120, DHB = 64;
    localparam int DVA = 600, DVF = 37, DVS = 6,   DVB = 23;
    localparam int D_HT = DHA + DHF + DHS + DHB;

    logic        clk = 1'b0;
    logic        rstS = 1'b1;
    logic        rstD = 1'b1;

    logic [10:0] hposS, hposD;
    logic [9:0]  vposS, vposD;
    logic        hsyncS, vsyncS, deS, lsS, fsS;
    logic        hsyncD, vsyncD, deD, lsD, fsD;
    logic [15:0] frameS, frameD;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int cyc        = 0;
    int tS         = -1;
    int tD         = -1;
    int lastFsS    = -1;
    int lastLsD    = -1;
    int hsFirstD   = -1;
    int hsCountD   = 0;
    int deCountD   = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .H_POL(SHP), .V_POL(SVP), .PIPE_DELAY(2)
    ) dutS (
        .clk48(clk), .rst(rstS), .hpos(hposS), .vpos(vposS),
        .hsync(hsyncS), .vsync(vsyncS), .de(deS),
        .line_start(lsS), .frame_start(fsS), .frame(frameS)
    );

    vga_sync_gen #(
        .PIPE_DELAY(2)
    ) dutD (
        .clk48(clk), .rst(rstD), .hpos(hposD), .vpos(vposD),
        .hsync(hsyncD), .vsync(vsyncD), .de(deD),
        .line_start(lsD), .frame_start(fsD), .frame(frameD)
    );

    // Expected {hpos,vpos,hsync,vsync,de,line_start,frame_start,frame} at time t
    // (t = cycles since the first post-release edge; negative means in reset).
    function automatic logic [41:0] model(input int t, input int ha, input int hf,
                                          input int hs, input int hb, input int va,
                                          input int vf, input int vs, input int vb,
                                          input int hp, input int vp, input int dly);
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int u;
        int uh;
        int uv;
        logic [10:0] h;
        logic [9:0]  v;
        logic [15:0] fr;
        logic hsO, vsO, deO, ls, fs;
        if (t < 0) begin
            h  = 11'(ht - 1);
            v  = 10'(vt - 1);
            fr = 16'hFFFF;
            ls = 1'b0;
            fs = 1'b0;
            u  = -1;
        end else begin
            h  = 11'(t % ht);
            v  = 10'((t / ht) % vt);
            fr = 16'((t / (ht * vt)) % 65536);
            ls = (h == 11'd0);
            fs = (h == 11'd0) && (v == 10'd0);
            u  = t - dly;
        end
        if (u < 0) begin
            deO = 1'b0;
            hsO = ~1'(hp);
            vsO = ~1'(vp);
        end else begin
            uh  = u % ht;
            uv  = (u / ht) % vt;
            deO = (uh < ha) && (uv < va);
            hsO = (uh >= ha + hf && uh < ha + hf + hs) ? 1'(hp) : ~1'(hp);
            vsO = (uv >= va + vf && uv < va + vf + vs) ? 1'(vp) : ~1'(vp);
        end
        return {h, v, hsO, vsO, deO, ls, fs, fr};
    endfunction

    // One comparison: count it, then assert observed against expected.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive the resets, advance n cycles, and check both instances after every edge.
    task automatic applyStimulus(input logic rS, input logic rD, input int n);
        for (int k = 0; k < n; k++) begin
            rstS = rS;
            rstD = rD;
            @(posedge clk);
            #1;
            cyc++;
            tS = rstS ? -1 : tS + 1;
            tD = rstD ? -1 : tD + 1;
            checkOutput("small_state",
                        64'({hposS, vposS, hsyncS, vsyncS, deS, lsS, fsS, frameS}),
                        64'(model(tS, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SHP, SVP, DLY)));
            checkOutput("default_state",
                        64'({hposD, vposD, hsyncD, vsyncD, deD, lsD, fsD, frameD}),
                        64'(model(tD, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1, 1, DLY)));
            if (rstS) begin
                lastFsS = -1;
            end else if (fsS) begin
                if (lastFsS >= 0) checkOutput("frame_start_period", 64'(cyc - lastFsS), 64'(S_FT));
                lastFsS = cyc;
            end
            if (lsD && !rstD) begin
                if (lastLsD >= 0) checkOutput("line_start_period", 64'(cyc - lastLsD), 64'(D_HT));
                lastLsD = cyc;
            end
            if (tD >= 0 && tD < D_HT) begin
                if (hsyncD) begin
                    hsCountD++;
                    if (hsFirstD < 0) hsFirstD = int'(hposD);
                end
                if (deD) deCountD++;
            end
        end
    endtask

    initial begin
        int runLen;
        int holdLen;

        // Reset held: both instances must sit at their reset values.
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("reset_frame", 64'(frameS), 64'hFFFF);

        // First edge after release: origin, strobes high, frame wrapped to 0.
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("release_frame_start", 64'(fsS), 64'd1);
        checkOutput("release_frame", 64'(frameS), 64'd0);

        // Two full small frames plus change: frame steps 0 -> 1 -> 2.
        applyStimulus(1'b0, 1'b0, 2 * S_FT + 40);
        checkOutput("frame_after_two", 64'(frameS), 64'd2);

        // Random mid-frame resets of random length on the small instance.
        for (int r = 0; r < 4; r++) begin
            runLen  = int'($urandom_range(20, S_FT - 1));
            holdLen = int'($urandom_range(1, 4));
            applyStimulus(1'b0, 1'b0, runLen);
            applyStimulus(1'b1, 1'b0, holdLen);
            checkOutput("midreset_hpos", 64'(hposS), 64'(S_HT - 1));
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("midreset_release_fs", 64'(fsS), 64'd1);
        end

        // Let the default instance finish at least two whole lines.
        if (tD < 2 * D_HT + 10) applyStimulus(1'b0, 1'b0, 2 * D_HT + 10 - tD);

        checkOutput("line0_hsync_first_hpos", 64'(hsFirstD), 64'(DHA + DHF + DLY));
        checkOutput("line0_hsync_width", 64'(hsCountD), 64'(DHS));
        checkOutput("line0_de_count", 64'(deCountD), 64'(DHA));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
